// File: rtl/axil_reg_slave_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes, FSM states
// and the byte-strobe merge helper.
package axil_reg_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_data,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
interface axil_reg_slave_if
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank with independent write/read FSMs and per-register write pulses.
// Define AXIL_REG_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  axil_reg_slave_if.slave         s_axi,
  output logic [NUM_REGS*32-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  wr_state_t         wr_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic              aw_have_q, w_have_q;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  resp_t             bresp_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic [31:0]       regs_q [NUM_REGS];

  rd_state_t         rd_state_q;
  logic              arready_q, rvalid_q;
  logic [31:0]       rdata_q;
  resp_t             rresp_q;

  logic              aw_fire, w_fire, ar_fire;
  logic [IDX_W-1:0]  ar_idx;
  logic [31:0]       rdata_d;
  resp_t             rresp_d;
  resp_t             bresp_d;

  assign aw_fire = s_axi.awvalid & awready_q;
  assign w_fire  = s_axi.wvalid  & wready_q;
  assign ar_fire = s_axi.arvalid & arready_q;
  assign ar_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef AXIL_REG_SLVERR_EN
  assign bresp_d = (int'(aw_idx_q) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
  assign rresp_d = (int'(ar_idx)   < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
`else
  assign bresp_d = RESP_OKAY;
  assign rresp_d = RESP_OKAY;
`endif

  // Out-of-range read indices match no register and fall through to zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rdata_d = regs_q[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      pulse_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pulse_q <= '0;
      case (wr_state_q)
        W_IDLE, W_WAIT: begin
          if (aw_fire) begin
            aw_idx_q  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            aw_have_q <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_fire) begin
            wdata_q  <= s_axi.wdata;
            wstrb_q  <= s_axi.wstrb;
            w_have_q <= 1'b1;
            wready_q <= 1'b0;
          end
          if ((aw_have_q || aw_fire) && (w_have_q || w_fire)) begin
            wr_state_q <= W_COMMIT;
          end else if (aw_fire || w_fire) begin
            wr_state_q <= W_WAIT;
          end else if (wr_state_q == W_IDLE) begin
            // Raises the READYs on the first cycle out of reset.
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx_q == IDX_W'(i)) begin
              regs_q[i]  <= strb_merge(regs_q[i], wdata_q, wstrb_q);
              pulse_q[i] <= 1'b1;
            end
          end
          aw_have_q  <= 1'b0;
          w_have_q   <= 1'b0;
          bvalid_q   <= 1'b1;
          bresp_q    <= bresp_d;
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs_q before any same-edge commit lands, so a collision returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs_q[i];
  end

  assign reg_wr_pulse  = pulse_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: drivers push expected B/R responses from a
// byte-level register model, a negedge monitor pops and compares them on each handshake.
module tb_axil_reg_slave;
  import axil_reg_pkg::*;

  localparam int NUM        = 3;
  localparam int CLK_PERIOD = 10;
  localparam int MAX_WAIT   = 60;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef struct {
    logic [1:0]         resp;
    logic [NUM*32-1:0]  regs;
  } bExp_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rExp_t;

  logic              aclk;
  logic              aresetn;
  logic [NUM*32-1:0] regQ;
  logic [NUM-1:0]    regWrPulse;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelRegs [NUM];
  int          expPulse  [NUM];
  int          seenPulse [NUM];
  bExp_t       bq[$];
  rExp_t       rq[$];
  bExp_t       bPop;
  rExp_t       rPop;

  axil_reg_slave_if #(.ADDR_WIDTH(4)) axi ();

  axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_REGS(NUM)
  ) dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .s_axi(axi),
    .reg_q(regQ),
    .reg_wr_pulse(regWrPulse)
  );

  initial aclk = 1'b0;
  always #(CLK_PERIOD/2) aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM*32-1:0] modelFlat();
    logic [NUM*32-1:0] flat;
    for (int i = 0; i < NUM; i++) flat[32*i +: 32] = modelRegs[i];
    return flat;
  endfunction

  function automatic logic [1:0] respFor(input logic [3:0] addr);
    return (int'(addr[3:2]) < NUM) ? 2'b00 : OOR_RESP;
  endfunction

  // Byte-enabled write into the model; a committed in-range write always counts one pulse.
  task automatic modelWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bExp_t e;
    int idx;
    idx = int'(addr[3:2]);
    if (idx < NUM) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) modelRegs[idx][8*b +: 8] = data[8*b +: 8];
      end
      expPulse[idx]++;
    end
    e.resp = respFor(addr);
    e.regs = modelFlat();
    bq.push_back(e);
  endtask

  task automatic modelRead(input logic [3:0] addr);
    rExp_t e;
    int idx;
    idx = int'(addr[3:2]);
    e.data = (idx < NUM) ? modelRegs[idx] : 32'h0;
    e.resp = respFor(addr);
    rq.push_back(e);
  endtask

  task automatic driveAw(input logic [3:0] addr, input int delay);
    int n;
    repeat (delay) @(negedge aclk);
    axi.awaddr  = addr;
    axi.awprot  = 3'($urandom);
    axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < MAX_WAIT) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("awready_seen", axi.awready, 1'b1);
    @(posedge aclk);
    #1 axi.awvalid = 1'b0;
  endtask

  task automatic driveW(input logic [31:0] data, input logic [3:0] strb, input int delay);
    int n;
    repeat (delay) @(negedge aclk);
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.wvalid = 1'b1;
    n = 0;
    while (!axi.wready && n < MAX_WAIT) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("wready_seen", axi.wready, 1'b1);
    @(posedge aclk);
    #1 axi.wvalid = 1'b0;
  endtask

  task automatic driveAr(input logic [3:0] addr, input int delay);
    int n;
    repeat (delay) @(negedge aclk);
    axi.araddr  = addr;
    axi.arprot  = 3'($urandom);
    axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < MAX_WAIT) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("arready_seen", axi.arready, 1'b1);
    @(posedge aclk);
    #1 axi.arvalid = 1'b0;
  endtask

  task automatic issueWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay);
    modelWrite(addr, data, strb);
    fork
      driveAw(addr, awDelay);
      driveW(data, strb, wDelay);
    join
  endtask

  task automatic issueRead(input logic [3:0] addr, input int delay);
    modelRead(addr);
    driveAr(addr, delay);
  endtask

  task automatic waitDrained();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < MAX_WAIT) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("responses_drained", (n < MAX_WAIT), 1'b1);
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awDelay, input int wDelay);
    if (isWrite) issueWrite(addr, data, strb, awDelay, wDelay);
    else         issueRead(addr, awDelay);
    waitDrained();
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      for (int i = 0; i < NUM; i++) begin
        if (regWrPulse[i]) seenPulse[i]++;
      end
      if (axi.bvalid && axi.bready) begin
        if (bq.size() == 0) begin
          checkOutput("b_unexpected", bq.size(), 1);
        end else begin
          bPop = bq.pop_front();
          checkOutput("bresp", axi.bresp, bPop.resp);
          checkOutput("reg_q_after_write", regQ, bPop.regs);
        end
      end
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) begin
          checkOutput("r_unexpected", rq.size(), 1);
        end else begin
          rPop = rq.pop_front();
          checkOutput("rdata", axi.rdata, rPop.data);
          checkOutput("rresp", axi.rresp, rPop.resp);
        end
      end
    end
  end

  initial begin
    #(50000 * CLK_PERIOD);
    bad++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [NUM*32-1:0] snap;
    logic [31:0]       rnd;
    int                lat;
    int                n;

    aresetn     = 1'b0;
    axi.awaddr  = '0;
    axi.awprot  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    axi.araddr  = '0;
    axi.arprot  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      modelRegs[i] = '0;
      expPulse[i]  = 0;
      seenPulse[i] = 0;
    end

    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", axi.awready, 1'b0);
    checkOutput("rst_wready", axi.wready, 1'b0);
    checkOutput("rst_arready", axi.arready, 1'b0);
    checkOutput("rst_bvalid", axi.bvalid, 1'b0);
    checkOutput("rst_rvalid", axi.rvalid, 1'b0);
    checkOutput("rst_bresp", axi.bresp, 2'b00);
    checkOutput("rst_rresp", axi.rresp, 2'b00);
    checkOutput("rst_rdata", axi.rdata, 32'h0);
    checkOutput("rst_reg_q", regQ, '0);
    checkOutput("rst_pulse", regWrPulse, '0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    $display("[TB] sequential writes and read-back");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i*4), 32'(i+1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'(i*4), '0, '0, 0, 0);
    for (int i = 0; i < NUM; i++) checkOutput("pulse_count_seq", seenPulse[i], expPulse[i]);

    $display("[TB] W ahead of AW");
    modelWrite(4'h4, 32'hDEADBEEF, 4'hF);
    axi.wdata  = 32'hDEADBEEF;
    axi.wstrb  = 4'hF;
    axi.wvalid = 1'b1;
    @(posedge aclk);
    #1 axi.wvalid = 1'b0;
    checkOutput("wready_dropped", axi.wready, 1'b0);
    repeat (2) @(negedge aclk);
    checkOutput("wready_held_low", axi.wready, 1'b0);
    axi.awaddr  = 4'h4;
    axi.awvalid = 1'b1;
    checkOutput("awready_waiting", axi.awready, 1'b1);
    @(posedge aclk);
    #1 axi.awvalid = 1'b0;
    lat = 1;
    while (!axi.bvalid && lat < MAX_WAIT) begin
      @(posedge aclk);
      #1 lat++;
    end
    checkOutput("bvalid_latency", lat, 2);
    waitDrained();
    checkOutput("reg1_deadbeef", regQ[63:32], 32'hDEADBEEF);

    $display("[TB] partial strobes");
    applyStimulus(1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 0, 0);
    applyStimulus(1'b1, 4'h8, 32'h12345678, 4'b0101, 1, 0);
    checkOutput("reg2_merge", regQ[95:64], 32'hFF34FF78);
    applyStimulus(1'b0, 4'h8, '0, '0, 0, 0);
    applyStimulus(1'b1, 4'h0, 32'hCAFEF00D, 4'h0, 0, 2);
    checkOutput("pulse_count_strb0", seenPulse[0], expPulse[0]);

    $display("[TB] B backpressure");
    axi.bready = 1'b0;
    issueWrite(4'h4, 32'hA5A5A5A5, 4'hF, 0, 0);
    n = 0;
    while (!axi.bvalid && n < MAX_WAIT) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("bvalid_stall_seen", axi.bvalid, 1'b1);
    fork
      issueWrite(4'h8, 32'h0BADCAFE, 4'hF, 0, 0);
      begin
        repeat (10) begin
          @(negedge aclk);
          checkOutput("stall_bvalid", axi.bvalid, 1'b1);
          checkOutput("stall_bresp", axi.bresp, 2'b00);
          checkOutput("stall_awready", axi.awready, 1'b0);
          checkOutput("stall_wready", axi.wready, 1'b0);
        end
        @(posedge aclk);
        #1 axi.bready = 1'b1;
      end
    join
    waitDrained();

    $display("[TB] read/commit collision");
    modelRead(4'h4);
    fork
      issueWrite(4'h4, 32'h11223344, 4'hF, 0, 0);
      begin
        @(posedge aclk);
        #1 driveAr(4'h4, 0);
      end
    join
    waitDrained();
    applyStimulus(1'b0, 4'h4, '0, '0, 0, 0);

    $display("[TB] out-of-range access");
    snap = regQ;
    applyStimulus(1'b1, 4'hC, 32'h000000AA, 4'hF, 0, 0);
    checkOutput("oor_no_change", regQ, snap);
    applyStimulus(1'b0, 4'hC, '0, '0, 0, 0);
    for (int i = 0; i < NUM; i++) checkOutput("pulse_count_oor", seenPulse[i], expPulse[i]);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 40; k++) begin
      rnd = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int i = 0; i < NUM; i++) checkOutput("pulse_count_rand", seenPulse[i], expPulse[i]);

    $display("[TB] reset during responses");
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    issueWrite(4'h8, 32'h55AA55AA, 4'hF, 0, 0);
    issueRead(4'h0, 0);
    repeat (2) @(negedge aclk);
    checkOutput("pre_rst_bvalid", axi.bvalid, 1'b1);
    checkOutput("pre_rst_rvalid", axi.rvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_bvalid", axi.bvalid, 1'b0);
    checkOutput("mid_rst_rvalid", axi.rvalid, 1'b0);
    checkOutput("mid_rst_reg_q", regQ, '0);
    checkOutput("mid_rst_awready", axi.awready, 1'b0);
    bq.delete();
    rq.delete();
    for (int i = 0; i < NUM; i++) modelRegs[i] = '0;
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    applyStimulus(1'b1, 4'h4, 32'h13579BDF, 4'hF, 0, 0);
    applyStimulus(1'b0, 4'h4, '0, '0, 0, 0);
    checkOutput("post_rst_reg1", regQ[63:32], 32'h13579BDF);
    for (int i = 0; i < NUM; i++) checkOutput("pulse_count_final", seenPulse[i], expPulse[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
